// File: rtl/alu_shift_stage_pkg.sv
`default_nettype none
// ============================================================================
// shift_pkg : shared defaults, shift opcodes and op legality check for
//             alu_shift_stage. Honours SHIFT_ROTATE_EN (enables ROL/ROR).
// Rev 1.0
// ============================================================================
package shift_pkg;

   localparam int XLEN_DEF = 32;
   localparam int SHW_DEF  = 5;
   localparam int TAGW_DEF = 5;

   typedef enum logic [2:0] {
      OP_SLL = 3'b000,
      OP_SRL = 3'b001,
      OP_SRA = 3'b010,
      OP_ROL = 3'b011,
      OP_ROR = 3'b100
   } shift_op_e;

   function automatic logic is_legal_op(input logic [2:0] op);
`ifdef SHIFT_ROTATE_EN
      return op inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};
`else
      return op inside {OP_SLL, OP_SRL, OP_SRA};
`endif
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shift_stage_if.sv
`default_nettype none
// ============================================================================
// alu_shift_stage_if : issue-side and writeback-side handshake bundle of the
//                      shift stage, plus the pipeline flush.
// Rev 1.0
// ============================================================================
interface alu_shift_stage_if #(
   parameter int XLEN = shift_pkg::XLEN_DEF,
   parameter int TAGW = shift_pkg::TAGW_DEF
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      in_op;
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_shamt;
   logic [TAGW-1:0] in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic [TAGW-1:0] out_tag;
   logic            out_err;

   modport master (
      output flush, in_valid, in_op, in_a, in_shamt, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_err
   );

   modport slave (
      input  flush, in_valid, in_op, in_a, in_shamt, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_err
   );
endinterface
`default_nettype wire

// File: rtl/alu_shift_stage_core.sv
`default_nettype none
// ============================================================================
// shift_core : combinational barrel shifter, log2 mux stages per direction.
//              Rotates (SHIFT_ROTATE_EN) OR a left and a right shift together.
// Rev 1.0
// ============================================================================
module shift_core
   import shift_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int SHW  = SHW_DEF
) (
   input  wire  [XLEN-1:0] a,
   input  wire  [SHW-1:0]  shamt,
   input  wire  [2:0]      op,
   output logic [XLEN-1:0] result
);

   logic [SHW-1:0]  w_lamt;
   logic [SHW-1:0]  w_ramt;
   logic            w_fill;
   logic [XLEN-1:0] w_l [SHW+1];
   logic [XLEN-1:0] w_r [SHW+1];

`ifdef SHIFT_ROTATE_EN
   // Opposite-direction amount is XLEN-s mod XLEN; s=0 leaves both halves = a.
   logic [SHW-1:0] w_neg;
   assign w_neg  = ~shamt + {{(SHW-1){1'b0}}, 1'b1};
   assign w_lamt = (op == OP_ROR) ? w_neg : shamt;
   assign w_ramt = (op == OP_ROL) ? w_neg : shamt;
`else
   assign w_lamt = shamt;
   assign w_ramt = shamt;
`endif

   assign w_fill = (op == OP_SRA) && a[XLEN-1];
   assign w_l[0] = a;
   assign w_r[0] = a;

   for (genvar i = 0; i < SHW; i++) begin : g_stage
      localparam int c_step = 1 << i;
      assign w_l[i+1] = w_lamt[i] ? {w_l[i][XLEN-1-c_step:0], {c_step{1'b0}}} : w_l[i];
      assign w_r[i+1] = w_ramt[i] ? {{c_step{w_fill}}, w_r[i][XLEN-1:c_step]} : w_r[i];
   end

   always_comb begin
      result = '0;
      case (op)
         OP_SLL:         result = w_l[SHW];
         OP_SRL, OP_SRA: result = w_r[SHW];
`ifdef SHIFT_ROTATE_EN
         OP_ROL, OP_ROR: result = w_l[SHW] | w_r[SHW];
`endif
         default:        result = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_shift_stage.sv
`default_nettype none
// ============================================================================
// alu_shift_stage : two-stage shift pipeline (operand reg -> result reg) with
//                   valid/ready, flush and error tagging. Macro: SHIFT_ROTATE_EN.
// Rev 1.0
// ============================================================================
module alu_shift_stage
   import shift_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int SHW  = SHW_DEF,
   parameter int TAGW = TAGW_DEF
) (
   input wire clk,
   input wire rst,
   alu_shift_stage_if.slave bus
);

   logic            r_s1_valid;
   logic [2:0]      r_s1_op;
   logic [XLEN-1:0] r_s1_a;
   logic [SHW-1:0]  r_s1_shamt;
   logic [TAGW-1:0] r_s1_tag;

   logic            r_s2_valid;
   logic [XLEN-1:0] r_s2_result;
   logic [TAGW-1:0] r_s2_tag;
   logic            r_s2_err;

   logic            w_s2_adv;
   logic            w_s1_adv;
   logic            w_accept;
   logic [XLEN-1:0] w_core_result;
   logic            w_unused_shamt;

   assign w_s2_adv     = !r_s2_valid || bus.out_ready;
   assign w_s1_adv     = r_s1_valid && w_s2_adv;
   assign bus.in_ready = !bus.flush && (!r_s1_valid || w_s2_adv);
   assign w_accept     = bus.in_valid && bus.in_ready;

   // Only the low SHW bits form the shift amount.
   assign w_unused_shamt = ^bus.in_shamt[XLEN-1:SHW];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= '0;
         r_s1_a     <= '0;
         r_s1_shamt <= '0;
         r_s1_tag   <= '0;
      end else if (bus.flush) begin
         r_s1_valid <= 1'b0;
      end else begin
         if (!r_s1_valid || w_s2_adv)
            r_s1_valid <= bus.in_valid;
         if (w_accept) begin
            r_s1_op    <= bus.in_op;
            r_s1_a     <= bus.in_a;
            r_s1_shamt <= bus.in_shamt[SHW-1:0];
            r_s1_tag   <= bus.in_tag;
         end
      end
   end

   shift_core #(
      .XLEN (XLEN),
      .SHW  (SHW)
   ) u_core (
      .a      (r_s1_a),
      .shamt  (r_s1_shamt),
      .op     (r_s1_op),
      .result (w_core_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid  <= 1'b0;
         r_s2_result <= '0;
         r_s2_tag    <= '0;
         r_s2_err    <= 1'b0;
      end else if (bus.flush) begin
         r_s2_valid <= 1'b0;
      end else begin
         if (w_s2_adv)
            r_s2_valid <= r_s1_valid;
         if (w_s1_adv) begin
            r_s2_result <= w_core_result;
            r_s2_tag    <= r_s1_tag;
            r_s2_err    <= !is_legal_op(r_s1_op);
         end
      end
   end

   assign bus.out_valid  = r_s2_valid;
   assign bus.out_result = r_s2_result;
   assign bus.out_tag    = r_s2_tag;
   assign bus.out_err    = r_s2_err;

endmodule
`default_nettype wire
